fetch_queue_unit: RTL and testbench
===================================

// Module: fetch_queue_unit
// PURPOSE
//  Parametrised instruction-fetch stage for the pipelined MIPS core; replaces the bare PC/+4/jump-mux front end.
//  Owns the PC and issues one instruction-memory read per cycle. Buffers returned instructions with their PC+4
//  in a DEPTH-entry queue and hands them to decode over a valid/ready handshake.
//  Accepts a redirect (branch/jump/jr resolved downstream) that flushes all queued and in-flight fetches.
// PARAMETERS
//  ADDR_W    32     PC / instruction-address width
//  DATA_W    32     instruction width
//  DEPTH     4      queue entries; power of two, >= 2
//  RESET_PC  'h0    PC loaded on reset (ADDR_W bits, word aligned)
// PORTS
//  Clk              in   1                 clock, rising edge
//  reset            in   1                 asynchronous, active-low reset
//  imem_req         out  1                 read request this cycle
//  imem_addr        out  ADDR_W            read address (= PC)
//  imem_rdata       in   DATA_W            read data; valid exactly one cycle after imem_req
//  redirect         in   1                 flush and restart fetch
//  redirect_pc      in   ADDR_W            new PC, sampled when redirect=1
//  id_valid         out  1                 queue head valid
//  id_ready         in   1                 decode accepts head
//  id_inst          out  DATA_W            head instruction; 0 (nop) when empty
//  id_pcplusfour    out  ADDR_W            head PC+4; 0 when empty
//  occupancy        out  $clog2(DEPTH+1)   entries held
// BEHAVIOUR
//  Reset (async, reset=0): PC<=RESET_PC, queue empty, inflight<=0; imem_req=0, id_valid=0, id_inst=0, id_pcplusfour=0, occupancy=0.
//  Any in-flight response is discarded.
//  Issue: imem_req = !redirect && (occupancy + inflight - pop < DEPTH), where pop = id_valid&&id_ready.
//  On issue: PC<=PC+4 (mod 2^ADDR_W; FFFFFFFC wraps to 0); inflight<=1, else inflight<=0.
//  Response: if inflight and !redirect, push {imem_rdata, issued_addr+4} at end of cycle.
//  Space is guaranteed by the issue rule, so no overflow is possible.
//  Latency: req in cycle N -> data in N+1 -> id_valid in N+2. Steady throughput is 1 instr/cycle for DEPTH>=2.
//  Handshake: entry leaves only when id_valid&&id_ready. Head stays stable while id_ready=0.
//  id_valid never depends combinationally on id_ready. Push and pop in the same cycle is legal.
//  Push and pop on an empty queue: no bypass; the entry appears next cycle.
//  Redirect in cycle R:
//   - imem_req=0 in R; the response arriving in R is dropped; queue cleared at end of R.
//   - A pop in R is still honoured; downstream squashes it.
//   - PC<=redirect_pc at end of R; fetch of redirect_pc issues in R+1; first new id_valid in R+3.
//   - Back-to-back redirects: the last one wins.
//  Full: occupancy==DEPTH with id_ready=0 -> imem_req=0, PC held.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs perf_redirects[31:0] and perf_stall_cycles[31:0].
//   - perf_redirects counts cycles with redirect=1.
//   - perf_stall_cycles counts cycles with id_valid=1 && id_ready=0.
//   - Both reset to 0 and wrap at 2^32.
//  Undefined: these ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  fetch_pkg: NOP_INST (32'h0), fetch_entry_t {inst, pcplusfour}, occupancy-width helper function.
//  Sub-module fetch_fifo: synchronous DEPTH x fetch_entry_t FIFO with push/pop/flush/count.
//  Flush has priority over push. PC, inflight tracking, issue logic and perf counters live in the top.
// TESTING
//  1 Reset release, RESET_PC=0, id_ready=1, imem[k]=k+0x100
//    -> imem_addr 0,4,8 on consecutive cycles; cycle 2 id_valid=1, id_inst=0x100, id_pcplusfour=4.
//  2 DEPTH=4, id_ready=0
//    -> occupancy reaches 4, imem_req=0, PC=0x10 held.
//    -> Then id_ready=1: heads 0x100..0x103 in order, then continuous stream with no gap.
//  3 occupancy=3, redirect=1 with redirect_pc=0x40
//    -> imem_req=0 that cycle; occupancy=0 next cycle; next imem_addr=0x40.
//    -> Two cycles later id_pcplusfour=0x44; no stale instruction delivered.
//  4 RESET_PC=FFFFFFF8 -> imem_addr FFFFFFF8, FFFFFFFC, 00000000; second entry id_pcplusfour=0.
//  5 Drop reset between edges mid-stream
//    -> imem_req, id_valid, occupancy go to 0 immediately; after release, fetch restarts at RESET_PC.
//  6 FETCH_PERF_EN: 3 redirects and 5 stalled-head cycles -> perf_redirects=3, perf_stall_cycles=5.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-stage types, constants and queue sizing helper
package fetch_pkg;
  localparam logic [31:0] NOP_INST = 32'h0;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pcplusfour;
  } fetch_entry_t;
  function automatic int occW(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fetch_queue_unit_if.sv
// fetch_queue_unit_if: instruction-memory, redirect and decode-side signals of the fetch stage
interface fetch_queue_unit_if import fetch_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4
) ();
  logic imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic id_valid;
  logic id_ready;
  logic [DATA_W-1:0] id_inst;
  logic [ADDR_W-1:0] id_pcplusfour;
  logic [occW(DEPTH)-1:0] occupancy;
  modport master (
    output imem_req, imem_addr, id_valid, id_inst, id_pcplusfour, occupancy,
    input imem_rdata, redirect, redirect_pc, id_ready
  );
  modport slave (
    input imem_req, imem_addr, id_valid, id_inst, id_pcplusfour, occupancy,
    output imem_rdata, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO; flush takes priority over push
module fetch_fifo import fetch_pkg::*; #(
  parameter type T = fetch_entry_t,
  parameter int DEPTH = 4
) (
  input logic Clk,
  input logic reset,
  input logic push,
  input logic pop,
  input logic flush,
  input T wrData,
  output T rdData,
  output logic [occW(DEPTH)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = occW(DEPTH);
  T mem [DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  assign rdData = mem[rdPtr];
  always_ff @(posedge Clk)
    if (push && !flush) mem[wrPtr] <= wrData;
  always_ff @(posedge Clk or negedge reset)
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtr + PW'(push);
      rdPtr <= rdPtr + PW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: owns the PC, issues one imem read per cycle and queues {inst, PC+4} for decode.
// Define FETCH_PERF_EN to add the perf_redirects / perf_stall_cycles counters.
module fetch_queue_unit import fetch_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic Clk,
  input logic reset,
  fetch_queue_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_stall_cycles
`endif
);
  typedef struct packed {
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] pcplusfour;
  } entry_t;
  localparam int CW = occW(DEPTH);
  logic [ADDR_W-1:0] pc;
  logic inflight, pop, issue;
  logic [CW-1:0] count;
  entry_t head, pushEntry;
  assign pop = bus.id_valid && bus.id_ready;
  // masked by reset so no request is visible while the unit is held in reset
  assign issue = reset && !bus.redirect && (32'(count) + 32'(inflight) - 32'(pop) < 32'(DEPTH));
  // while a response is in flight, pc already holds the issued address + 4
  assign pushEntry = '{inst: bus.imem_rdata, pcplusfour: pc};
  assign bus.imem_req = issue;
  assign bus.imem_addr = pc;
  assign bus.id_valid = count != '0;
  assign bus.id_inst = bus.id_valid ? head.inst : DATA_W'(NOP_INST);
  assign bus.id_pcplusfour = bus.id_valid ? head.pcplusfour : '0;
  assign bus.occupancy = count;
  fetch_fifo #(.T(entry_t), .DEPTH(DEPTH)) fifo (
    .Clk(Clk),
    .reset(reset),
    .push(inflight && !bus.redirect),
    .pop(pop),
    .flush(bus.redirect),
    .wrData(pushEntry),
    .rdData(head),
    .count(count)
  );
  always_ff @(posedge Clk or negedge reset)
    if (!reset) begin
      pc <= RESET_PC;
      inflight <= 1'b0;
    end else begin
      pc <= bus.redirect ? bus.redirect_pc : issue ? pc + ADDR_W'(4) : pc;
      inflight <= issue;
    end
`ifdef FETCH_PERF_EN
  always_ff @(posedge Clk or negedge reset)
    if (!reset) begin
      perf_redirects <= '0;
      perf_stall_cycles <= '0;
    end else begin
      perf_redirects <= perf_redirects + 32'(bus.redirect);
      perf_stall_cycles <= perf_stall_cycles + 32'(bus.id_valid && !bus.id_ready);
    end
`endif
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: randomized fetch/decode traffic checked against a queue-based reference model
`timescale 1ns/1ps
module tb_fetch_queue_unit;
  import fetch_pkg::*;
  localparam int DEPTH = 4;
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
  } ent_t;
  logic Clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  fetch_queue_unit_if #(.DEPTH(DEPTH)) bus ();
  fetch_queue_unit_if #(.DEPTH(DEPTH)) wbus ();
`ifdef FETCH_PERF_EN
  logic [31:0] perfRedir, perfStall, wPerfRedir, wPerfStall;
`endif
  fetch_queue_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .Clk(Clk),
    .reset(reset),
    .bus(bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_redirects(perfRedir),
    .perf_stall_cycles(perfStall)
`endif
  );
  fetch_queue_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) wdut (
    .Clk(Clk),
    .reset(reset),
    .bus(wbus)
`ifdef FETCH_PERF_EN
    ,
    .perf_redirects(wPerfRedir),
    .perf_stall_cycles(wPerfStall)
`endif
  );
  always #5 Clk = ~Clk;
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a >> 2) + 32'h100;
  endfunction
  // instruction memory: data one cycle after a request, garbage otherwise
  always @(posedge Clk) begin
    bus.imem_rdata <= bus.imem_req ? memWord(bus.imem_addr) : $urandom;
    wbus.imem_rdata <= wbus.imem_req ? memWord(wbus.imem_addr) : $urandom;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge Clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  ent_t mq[$];
  logic [31:0] mPc = 32'h0;
  logic [31:0] mIss = 32'h0;
  logic mInfl = 1'b0;
  logic [31:0] mRedir = 32'h0;
  logic [31:0] mStall = 32'h0;
  always @(negedge Clk) begin : cmp
    logic p, r, v;
    ent_t e;
    if (!reset) begin
      chk("rst_req", bus.imem_req, 0);
      chk("rst_valid", bus.id_valid, 0);
      chk("rst_inst", bus.id_inst, 0);
      chk("rst_pc4", bus.id_pcplusfour, 0);
      chk("rst_occ", bus.occupancy, 0);
`ifdef FETCH_PERF_EN
      chk("rst_perf_redir", perfRedir, 0);
      chk("rst_perf_stall", perfStall, 0);
`endif
      mq.delete();
      mPc = 32'h0;
      mInfl = 1'b0;
      mRedir = 32'h0;
      mStall = 32'h0;
    end else begin
      v = mq.size() > 0;
      p = v && bus.id_ready;
      r = !bus.redirect && (mq.size() + int'(mInfl) - int'(p) < DEPTH);
      chk("req", bus.imem_req, r);
      chk("addr", bus.imem_addr, mPc);
      chk("valid", bus.id_valid, v);
      chk("inst", bus.id_inst, v ? mq[0].inst : 32'h0);
      chk("pc4", bus.id_pcplusfour, v ? mq[0].pc4 : 32'h0);
      chk("occ", bus.occupancy, mq.size());
`ifdef FETCH_PERF_EN
      chk("perf_redir", perfRedir, mRedir);
      chk("perf_stall", perfStall, mStall);
`endif
      mRedir += 32'(bus.redirect);
      mStall += 32'(v && !bus.id_ready);
      if (p) void'(mq.pop_front());
      if (bus.redirect) mq.delete();
      else if (mInfl) begin
        e.inst = memWord(mIss);
        e.pc4 = mIss + 32'd4;
        mq.push_back(e);
      end
      mInfl = r;
      if (r) mIss = mPc;
      mPc = bus.redirect ? bus.redirect_pc : r ? mPc + 32'd4 : mPc;
    end
  end
  initial begin
    bus.id_ready = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    wbus.id_ready = 1'b1;
    wbus.redirect = 1'b0;
    wbus.redirect_pc = 32'h0;
    repeat (2) @(posedge Clk);
    #1 reset = 1'b1;
    settle();
    chk("t1_req0", bus.imem_req, 1);
    chk("t1_addr0", bus.imem_addr, 32'h0);
    chk("t4_addr0", wbus.imem_addr, 32'hFFFF_FFF8);
    step();
    settle();
    chk("t1_addr1", bus.imem_addr, 32'h4);
    chk("t4_addr1", wbus.imem_addr, 32'hFFFF_FFFC);
    step();
    settle();
    chk("t1_addr2", bus.imem_addr, 32'h8);
    chk("t1_valid2", bus.id_valid, 1);
    chk("t1_inst2", bus.id_inst, 32'h100);
    chk("t1_pc4_2", bus.id_pcplusfour, 32'h4);
    chk("t4_addr2", wbus.imem_addr, 32'h0);
    chk("t4_pc4_first", wbus.id_pcplusfour, 32'hFFFF_FFFC);
    step();
    settle();
    chk("t4_pc4_wrap", wbus.id_pcplusfour, 32'h0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    bus.id_ready = 1'b0;
    repeat (6) step();
    settle();
    chk("t2_occ_full", bus.occupancy, 4);
    chk("t2_req_off", bus.imem_req, 0);
    chk("t2_pc_held", bus.imem_addr, 32'h10);
    bus.id_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk("t2_stream_valid", bus.id_valid, 1);
      chk("t2_stream_inst", bus.id_inst, 32'h100 + 32'(i));
      step();
    end
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h40;
    settle();
    chk("t3_pre_occ", bus.occupancy, 3);
    chk("t3_req_off", bus.imem_req, 0);
    step();
    bus.redirect = 1'b0;
    settle();
    chk("t3_occ_clr", bus.occupancy, 0);
    chk("t3_addr", bus.imem_addr, 32'h40);
    chk("t3_req_on", bus.imem_req, 1);
    step();
    settle();
    chk("t3_no_stale", bus.id_valid, 0);
    step();
    settle();
    chk("t3_valid", bus.id_valid, 1);
    chk("t3_pc4", bus.id_pcplusfour, 32'h44);
    chk("t3_inst", bus.id_inst, 32'h110);
    for (int i = 0; i < 3000; i++) begin
      step();
      bus.id_ready = $urandom_range(0, 9) < 7;
      bus.redirect = $urandom_range(0, 15) == 0;
      bus.redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4
                                                     : $urandom & ~32'h3;
      if (i >= 1490 && i <= 1500) begin
        bus.id_ready = 1'b0;
        bus.redirect = 1'b0;
      end
      if (i == 1500) begin
        settle();
        chk("t5_pre_occ", bus.occupancy, 4);
        #1 reset = 1'b0;
        #1;
        chk("t5_req", bus.imem_req, 0);
        chk("t5_valid", bus.id_valid, 0);
        chk("t5_occ", bus.occupancy, 0);
        step();
        step();
        reset = 1'b1;
        bus.id_ready = 1'b1;
        settle();
        chk("t5_restart_addr", bus.imem_addr, 32'h0);
        chk("t5_restart_req", bus.imem_req, 1);
      end
    end
    step();
    bus.id_ready = 1'b1;
    bus.redirect = 1'b0;
`ifdef FETCH_PERF_EN
    reset = 1'b0;
    step();
    reset = 1'b1;
    repeat (3) step();
    bus.id_ready = 1'b0;
    repeat (5) step();
    bus.id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h80;
      step();
      bus.redirect = 1'b0;
      step();
    end
    settle();
    chk("t6_perf_redir", perfRedir, 3);
    chk("t6_perf_stall", perfStall, 5);
`endif
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
